// File: rtl/tlul_pkg.sv
// TileLink Uncached Lightweight (TL-UL) channel definitions.
// Contents: the A-channel and D-channel opcode enums, the A-channel user
// field type and its default, and the packed host-to-device (tl_h2d_t) and
// device-to-host (tl_d2h_t) channel structs. The bus is 32-bit data,
// 32-bit address, 8-bit source.
package tlul_pkg;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef logic [15:0] tl_a_user_t;

  parameter tl_a_user_t TL_A_USER_DEFAULT = 16'h0000;

  typedef struct packed {
    logic        a_valid;
    tl_a_op_e    a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    tl_a_user_t  a_user;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    tl_d_op_e    d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

endpackage

// File: rtl/tlul_host_adapter.sv
// Bridges a simple req/gnt local bus onto a TL-UL host port, one
// transaction in flight at a time.
//
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   req_i              local request valid, held until gnt_o
//   we_i               1 = write, 0 = read
//   addr_i             byte address (bits [1:0] ignored)
//   wdata_i, be_i      write data and byte enables
//   gnt_o              request accepted on the bus (one-cycle pulse)
//   valid_o            response pulse; rdata_o / err_o valid with it
//   busy_o             a transaction is outstanding
//   tl_o, tl_i         TL-UL host-to-device / device-to-host channels
//
// Timing: a request is registered in IDLE, presented on the A channel in
// ADDR, and the response (or timeout) is awaited in DATA. All status outputs
// are flops, so nothing on tl_i reaches gnt_o/valid_o combinationally.
module tlul_host_adapter
  import tlul_pkg::*;
#(
  parameter logic [7:0]  SourceId      = 8'h00,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  be_i,
  output logic        gnt_o,
  output logic        valid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        busy_o,
  output tl_h2d_t     tl_o,
  input  tl_d2h_t     tl_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_e;

  // The counter "reaches" TimeoutCycles on the edge where it would step
  // from TimeoutCycles-1, so the error pulse lands TimeoutCycles cycles
  // after entering DATA.
  localparam logic [15:0] TimeoutLast = 16'(TimeoutCycles - 1);

  state_e      state_q, state_d;
  logic        req_we_q;
  logic [29:0] req_word_q;
  logic [31:0] req_wdata_q;
  logic [3:0]  req_be_q;
  logic [15:0] wait_cnt_q;
  logic        gnt_q, valid_q, err_q;
  logic [31:0] rdata_q;

  logic a_fire, rsp_fire, timeout, rsp_err;
  tl_d_op_e exp_d_op;

  assign a_fire   = (state_q == ADDR) && tl_i.a_ready;
  assign rsp_fire = (state_q == DATA) && tl_i.d_valid;
  // A response arriving on the timeout edge takes priority over the timeout.
  assign timeout  = (state_q == DATA) && !tl_i.d_valid && (wait_cnt_q == TimeoutLast);

  assign exp_d_op = req_we_q ? AccessAck : AccessAckData;
  assign rsp_err  = tl_i.d_error || (tl_i.d_source != SourceId) ||
                    (tl_i.d_opcode != exp_d_op);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic.
  // NOTE: every always_comb output gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_i) state_d = ADDR;
      ADDR:    if (tl_i.a_ready) state_d = DATA;
      DATA:    if (tl_i.d_valid || timeout) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: the A channel is a pure function of state and the
  // registered request.
  always_comb begin
    tl_o           = '0;
    tl_o.a_valid   = (state_q == ADDR);
    tl_o.a_opcode  = !req_we_q          ? Get :
                     (req_be_q == 4'hF) ? PutFullData : PutPartialData;
    tl_o.a_param   = 3'h0;
    tl_o.a_size    = 2'd2;
    tl_o.a_source  = SourceId;
    tl_o.a_address = {req_word_q, 2'b00};
    tl_o.a_mask    = req_we_q ? req_be_q : 4'hF;
    tl_o.a_data    = req_we_q ? req_wdata_q : 32'h0;
    tl_o.a_user    = TL_A_USER_DEFAULT;
    tl_o.d_ready   = 1'b1;
  end

  assign busy_o = (state_q != IDLE);

  // Request capture, wait counter and registered response.
  // NOTE: the request holding registers are reset too, so tl_o never shows
  // X after reset even though a_valid is low.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_we_q    <= 1'b0;
      req_word_q  <= '0;
      req_wdata_q <= '0;
      req_be_q    <= '0;
      wait_cnt_q  <= '0;
      gnt_q       <= 1'b0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
    end else begin
      if ((state_q == IDLE) && req_i) begin
        req_we_q    <= we_i;
        req_word_q  <= addr_i[31:2];
        req_wdata_q <= wdata_i;
        req_be_q    <= be_i;
      end

      if (a_fire)                                    wait_cnt_q <= '0;
      else if ((state_q == DATA) && !tl_i.d_valid)   wait_cnt_q <= wait_cnt_q + 16'd1;

      gnt_q   <= a_fire;
      valid_q <= rsp_fire || timeout;
      err_q   <= rsp_fire ? rsp_err : timeout;
      rdata_q <= (rsp_fire && !req_we_q) ? tl_i.d_data : 32'h0;
    end
  end

  assign gnt_o   = gnt_q;
  assign valid_o = valid_q;
  assign err_o   = err_q;
  assign rdata_o = rdata_q;

  // Fields the adapter has no use for.
  logic unused_fields;
  assign unused_fields = ^{addr_i[1:0], tl_i.d_param, tl_i.d_size, tl_i.d_sink};

endmodule

// File: tb/tb_tlul_host_adapter.sv
// Self-checking bench for tlul_host_adapter. The stimulus process plays
// both the local requester and the TL-UL device; for each transaction it
// pushes the expected response (data, error, arrival cycle) into a queue
// and a separate monitor pops and compares whenever valid_o is seen.
module tb_tlul_host_adapter;
  import tlul_pkg::*;

  localparam logic [7:0] SRC = 8'h00;
  localparam int         TO  = 8;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_i, we_i;
  logic [31:0] addr_i, wdata_i;
  logic [3:0]  be_i;
  logic        gnt_o, valid_o, err_o, busy_o;
  logic [31:0] rdata_o;
  tl_h2d_t     tl_o;
  tl_d2h_t     tl_i;

  tlul_host_adapter #(.SourceId(SRC), .TimeoutCycles(TO)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .req_i(req_i), .we_i(we_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .be_i(be_i), .gnt_o(gnt_o),
    .valid_o(valid_o), .rdata_o(rdata_o), .err_o(err_o), .busy_o(busy_o),
    .tl_o(tl_o), .tl_i(tl_i)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          at;
  } rsp_t;
  rsp_t exp_q[$];

  // Monitor: every valid_o must match the oldest expected response.
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      if (valid_o) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_valid: got valid_o=1 rdata=%h err=%b, expected no response (cycle %0d)",
                   rdata_o, err_o, cyc);
        end else begin
          e = exp_q.pop_front();
          check("rsp_rdata", rdata_o, e.rdata);
          check("rsp_err", 32'(err_o), 32'(e.err));
          check("rsp_cycle", cyc, e.at);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  typedef enum {M_OK, M_DERR, M_BADSRC, M_BADOP, M_TIMEOUT, M_RESET} mode_e;

  // One complete transaction. Starts and ends on a negedge with the DUT idle.
  task automatic run_txn(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input int ready_wait, input int rsp_delay,
                         input mode_e mode, input logic [31:0] d_data, input bit stale);
    logic [2:0]  e_op;
    logic [31:0] e_addr, e_data;
    logic [3:0]  e_mask;
    logic [2:0]  d_op;
    logic [7:0]  d_src;
    logic        d_err;
    int          c_enter;
    rsp_t        r;

    // Expected A-channel contents straight from the opcode/mask rules.
    if (!we)             e_op = 3'd4;
    else if (be == 4'hF) e_op = 3'd0;
    else                 e_op = 3'd1;
    e_addr = addr & 32'hFFFF_FFFC;
    e_mask = we ? be : 4'hF;
    e_data = we ? wdata : 32'h0;

    req_i = 1'b1; we_i = we; addr_i = addr; wdata_i = wdata; be_i = be;
    @(negedge clk);
    check("a_valid_up", 32'(tl_o.a_valid), 32'd1);
    check("busy_addr", 32'(busy_o), 32'd1);

    for (int i = 0; i <= ready_wait; i++) begin
      // A stray D beat while in ADDR must be ignored.
      tl_i.d_valid = (i == 1);
      check("a_opcode", 32'(tl_o.a_opcode), 32'(e_op));
      check("a_address", tl_o.a_address, e_addr);
      check("a_mask", 32'(tl_o.a_mask), 32'(e_mask));
      check("a_data", tl_o.a_data, e_data);
      check("a_meta", {tl_o.a_source, 6'(tl_o.a_param), 2'(tl_o.a_size), tl_o.a_user},
            {SRC, 6'd0, 2'd2, TL_A_USER_DEFAULT});
      check("gnt_wait", 32'(gnt_o), 32'd0);
      if (i == ready_wait) tl_i.a_ready = 1'b1;
      @(negedge clk);
      tl_i.d_valid = 1'b0;
    end

    // The handshake edge has passed: DUT is in DATA for its first cycle.
    tl_i.a_ready = 1'b0;
    req_i = 1'b0; we_i = $urandom; addr_i = $urandom; wdata_i = $urandom; be_i = 4'($urandom);
    c_enter = cyc;
    check("gnt_pulse", 32'(gnt_o), 32'd1);
    check("a_valid_down", 32'(tl_o.a_valid), 32'd0);
    check("busy_data", 32'(busy_o), 32'd1);
    check("d_ready", 32'(tl_o.d_ready), 32'd1);

    if (mode == M_TIMEOUT) begin
      r.rdata = 32'h0; r.err = 1'b1; r.at = c_enter + TO;
      exp_q.push_back(r);
      repeat (TO) begin
        @(negedge clk);
        if (cyc < c_enter + TO) check("busy_wait", 32'(busy_o), 32'd1);
      end
    end else if (mode == M_RESET) begin
      @(negedge clk);
      @(negedge clk);
      rst_ni = 1'b0;
      #1;
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_outs", {28'd0, gnt_o, valid_o, err_o, tl_o.a_valid}, 32'd0);
      check("rst_rdata", rdata_o, 32'd0);
      @(negedge clk);
      rst_ni = 1'b1;
      @(negedge clk);
      tl_i.d_valid = 1'b1; tl_i.d_opcode = we ? AccessAck : AccessAckData;
      tl_i.d_source = SRC; tl_i.d_error = 1'b0; tl_i.d_data = d_data;
      @(negedge clk);
      tl_i.d_valid = 1'b0;
    end else begin
      repeat (rsp_delay) @(negedge clk);
      d_op  = we ? 3'd0 : 3'd1;
      d_src = SRC;
      d_err = 1'b0;
      if (mode == M_DERR)   d_err = 1'b1;
      if (mode == M_BADSRC) d_src = 8'h01;
      if (mode == M_BADOP)  d_op  = we ? 3'd1 : 3'd0;
      tl_i.d_valid = 1'b1; tl_i.d_opcode = tl_d_op_e'(d_op); tl_i.d_source = d_src;
      tl_i.d_error = d_err; tl_i.d_data = d_data;
      r.rdata = we ? 32'h0 : d_data;
      r.err   = d_err || (d_src != SRC) || (d_op != (we ? 3'd0 : 3'd1));
      r.at    = cyc + 1;
      exp_q.push_back(r);
      @(negedge clk);
      tl_i.d_valid = 1'b0;
      check("gnt_once", 32'(gnt_o), 32'd0);
    end
    check("busy_done", 32'(busy_o), 32'd0);

    if (stale) begin
      tl_i.d_valid = 1'b1; tl_i.d_opcode = we ? AccessAck : AccessAckData;
      tl_i.d_source = SRC; tl_i.d_error = 1'b0;
      @(negedge clk);
      tl_i.d_valid = 1'b0;
      check("busy_stale", 32'(busy_o), 32'd0);
    end
  endtask

  initial begin
    mode_e m;
    int    pick;
    req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0; be_i = '0;
    tl_i = '0;

    #2;
    check("reset_busy", 32'(busy_o), 32'd0);
    check("reset_outs", {28'd0, gnt_o, valid_o, err_o, tl_o.a_valid}, 32'd0);
    check("reset_rdata", rdata_o, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);

    // Directed cases.
    run_txn(1'b0, 32'h104, 32'h0, 4'hF, 0, 1, M_OK, 32'hDEADBEEF, 1'b0);
    run_txn(1'b1, 32'h10C, 32'h5, 4'h3, 0, 0, M_OK, 32'h1234_5678, 1'b0);
    run_txn(1'b1, 32'h200, 32'hCAFE_F00D, 4'hF, 5, 2, M_OK, 32'h0, 1'b0);
    run_txn(1'b0, 32'h300, 32'h0, 4'hF, 1, 0, M_TIMEOUT, 32'h0, 1'b1);
    run_txn(1'b0, 32'h304, 32'h0, 4'hF, 0, TO - 1, M_OK, 32'hA5A5_0001, 1'b0);
    run_txn(1'b0, 32'h308, 32'h0, 4'hF, 0, 0, M_DERR, 32'h7777_0000, 1'b0);
    run_txn(1'b1, 32'h30C, 32'h9, 4'h1, 0, 3, M_BADSRC, 32'h0, 1'b0);
    run_txn(1'b0, 32'h310, 32'h0, 4'hF, 0, 1, M_BADOP, 32'h1111_2222, 1'b0);
    run_txn(1'b1, 32'h314, 32'h42, 4'hF, 0, 0, M_RESET, 32'h0, 1'b0);

    // Randomized back-to-back traffic.
    for (int n = 0; n < 40; n++) begin
      pick = $urandom_range(0, 9);
      if (pick < 5)       m = M_OK;
      else if (pick == 5) m = M_DERR;
      else if (pick == 6) m = M_BADSRC;
      else if (pick == 7) m = M_BADOP;
      else if (pick == 8) m = M_TIMEOUT;
      else                m = M_OK;
      run_txn(1'($urandom), $urandom, $urandom, 4'($urandom_range(1, 15)),
              $urandom_range(0, 4), $urandom_range(0, TO - 1), m, $urandom,
              1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tlul_host_adapter.md
TLUL_HOST_ADAPTER -- requirements
Module: tlul_host_adapter

Interface
REQ-001 SHALL have parameter SourceId, default 8'h00: a_source value driven on every request.
REQ-002 SHALL have parameter TimeoutCycles, default 1024: response-wait limit in cycles, range 1..65535.
REQ-003 SHALL have port clk_i  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset; asynchronous assert, active-low.
REQ-005 SHALL have port req_i  input  1  local request valid; held until gnt_o.
REQ-006 SHALL have port we_i  input  1  1 = write, 0 = read.
REQ-007 SHALL have port addr_i  input  32  byte address; bits [1:0] ignored.
REQ-008 SHALL have port wdata_i  input  32  write data.
REQ-009 SHALL have port be_i  input  4  write byte enables.
REQ-010 SHALL have port gnt_o  output  1  request accepted, one-cycle pulse.
REQ-011 SHALL have port valid_o  output  1  response pulse, one cycle.
REQ-012 SHALL have port rdata_o  output  32  read data, valid with valid_o.
REQ-013 SHALL have port err_o  output  1  response error, valid with valid_o.
REQ-014 SHALL have port busy_o  output  1  transaction outstanding.
REQ-015 SHALL have port tl_o  output  tlul_pkg::tl_h2d_t  TL-UL host-to-device channel.
REQ-016 SHALL have port tl_i  input  tlul_pkg::tl_d2h_t  TL-UL device-to-host channel.

Function
REQ-017 SHALL implement FSM states IDLE, ADDR and DATA, with at most one outstanding transaction.
REQ-018 In IDLE with req_i=1, SHALL register the request fields and move to ADDR next cycle; gnt_o SHALL NOT assert yet.
REQ-019 In ADDR, SHALL drive a_valid=1 with the registered request; on a_valid&a_ready, SHALL pulse gnt_o and go to DATA.
REQ-020 a_opcode SHALL be Get (4) for reads, PutFullData (0) for writes with be=4'hF, and PutPartialData (1) for other writes.
REQ-021 SHALL drive a_size=2, a_address={addr[31:2],2'b00}, a_mask=4'hF for reads and be for writes, a_data=wdata for writes and 0 for reads, a_source=SourceId, a_param=0, a_user=tlul_pkg::TL_A_USER_DEFAULT.
REQ-022 SHALL drive d_ready=1 in every state; a d_valid seen in IDLE or ADDR SHALL be discarded with no output effect.
REQ-023 In DATA, on d_valid, SHALL pulse valid_o on the next cycle and return to IDLE.
REQ-024 In that response, rdata_o SHALL be d_data for reads and 0 for writes.
REQ-025 err_o SHALL be d_error OR (d_source!=SourceId) OR an opcode mismatch; the expected opcode is AccessAckData (1) for Get and AccessAck (0) for Put.
REQ-026 A 16-bit wait counter SHALL clear on entering DATA and increment each DATA cycle without d_valid.
REQ-027 When the wait counter reaches TimeoutCycles, SHALL pulse valid_o with err_o=1 and rdata_o=0, then return to IDLE; a later stale response is discarded per REQ-022.
REQ-028 If d_valid arrives in the same cycle the counter reaches TimeoutCycles, the response SHALL win and no timeout error is reported.
REQ-029 busy_o SHALL be 1 in ADDR and DATA and 0 in IDLE.
REQ-030 req_i SHALL be ignored outside IDLE; back-to-back requests SHALL be allowed with a minimum 1-cycle IDLE.
REQ-031 gnt_o, valid_o, err_o and busy_o SHALL each be registered or derived from state only, with no combinational path from tl_i.d_valid to gnt_o.

Reset
REQ-032 On rst_ni=0, SHALL enter IDLE immediately with a_valid=0, gnt_o=0, valid_o=0, err_o=0, rdata_o=0, busy_o=0 and the counter at 0.
REQ-033 Reset mid-transaction SHALL abandon the transaction silently; a response arriving after reset release SHALL be discarded.

Verification
REQ-034 Read addr_i=32'h104 against a device responding AccessAckData with d_data=32'hDEADBEEF -> a_opcode=4, a_address=32'h104, then valid_o=1, rdata_o=32'hDEADBEEF, err_o=0.
REQ-035 Write addr_i=32'h10C, wdata_i=32'h5, be_i=4'h3 -> a_opcode=1, a_mask=4'h3, a_data=32'h5; AccessAck gives valid_o=1, rdata_o=0, err_o=0.
REQ-036 Device holds a_ready=0 for 5 cycles -> a_valid stays 1 with stable fields, and gnt_o pulses exactly once on the cycle a_ready rises.
REQ-037 TimeoutCycles=8 and no response -> valid_o=1, err_o=1 eight cycles after entering DATA; a response injected later produces no valid_o.
REQ-038 Response with d_error=1, or d_source=8'h01 when SourceId=0 -> valid_o=1, err_o=1.
REQ-039 rst_ni asserted in DATA, then deasserted, then a response delivered -> busy_o=0 and no valid_o pulse.
